// File: rtl/kyber_pkg.sv
// Shared Kyber constants and the accumulator FSM state encoding.
package kyber_pkg;

  localparam int KYBER_Q   = 3329;
  localparam int BARRETT_V = 20159;

  typedef enum logic [1:0] {
    IDLE,
    ACC,
    OUT,
    DONE
  } state_e;

endpackage

// File: rtl/barrett_reduce.sv
// Combinational Barrett reduction of a signed 16-bit value into [0, q-1].
module barrett_reduce
  import kyber_pkg::*;
#(
  parameter int Q = KYBER_Q,
  parameter int V = BARRETT_V
) (
  input  logic signed [15:0] a,
  output logic        [15:0] r
);

  logic signed [31:0] prod;
  logic signed [31:0] t;
  logic signed [15:0] rem;

  // Rounded quotient leaves a centred remainder; one conditional add makes it non-negative.
  always_comb begin
    prod = 32'(V) * 32'(a);
    t    = (prod + 32'sd33554432) >>> 26;
    rem  = 16'(32'(a) - t * 32'(Q));
    r    = (rem < 0) ? 16'(rem + 16'(Q)) : 16'(rem);
  end

endmodule

// File: rtl/polyvec_acc.sv
// Accumulates K polynomials of coefficient pairs into two RAM banks, then streams
// the Barrett-reduced sums out in index order with valid/ready flow control.
module polyvec_acc
  import kyber_pkg::*;
#(
  parameter int DEPTH   = 8,
  parameter int K       = 2,
  parameter int KYBER_Q = kyber_pkg::KYBER_Q
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             set,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      acc_din_1,
  input  logic [15:0]      acc_din_2,
  input  logic [DEPTH-1:0] in_index,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [15:0]      acc_dout_1,
  output logic [15:0]      acc_dout_2,
  output logic [DEPTH-1:0] out_index,
  output logic             done
);

  localparam int AW    = DEPTH - 1;
  localparam int NPAIR = 1 << AW;

  logic signed [15:0] mem_even [NPAIR];
  logic signed [15:0] mem_odd  [NPAIR];

  state_e             state_q, state_d;
  logic [AW-1:0]      pair_cnt_q, pair_cnt_d;
  logic [1:0]         poly_cnt_q, poly_cnt_d;
  logic               in_ready_q, in_ready_d;

  logic               s1_valid_q, s1_valid_d;
  logic               s1_first_q, s1_first_d;
  logic [AW-1:0]      s1_addr_q, s1_addr_d;
  logic signed [15:0] s1_din1_q, s1_din1_d;
  logic signed [15:0] s1_din2_q, s1_din2_d;

  logic [AW-1:0]      rd_cnt_q, rd_cnt_d;
  logic               issued_q, issued_d;
  logic               p1_valid_q, p1_valid_d;
  logic [AW-1:0]      p1_idx_q, p1_idx_d;

  logic               out_valid_q, out_valid_d;
  logic [15:0]        dout1_q, dout1_d;
  logic [15:0]        dout2_q, dout2_d;
  logic [DEPTH-1:0]   out_index_q, out_index_d;
  logic               done_q, done_d;

  logic               rd_en;
  logic [AW-1:0]      rd_addr;
  logic signed [15:0] rd_e_q, rd_o_q;
  logic signed [15:0] fwd_e_q, fwd_o_q;
  logic               fwd_q;
  logic signed [15:0] op_e, op_o, wr_e, wr_o;
  logic [15:0]        red_e, red_o;
  logic               xfer, advance, issue, last_acc, last_out;
  logic               unused_idx_lsb;

  barrett_reduce #(.Q(KYBER_Q)) u_red_even (.a(op_e), .r(red_e));
  barrett_reduce #(.Q(KYBER_Q)) u_red_odd  (.a(op_o), .r(red_o));

  always_comb begin
    unused_idx_lsb = in_index[0];
    xfer     = in_valid && in_ready_q;
    advance  = !out_valid_q || out_ready;
    issue    = (state_q == OUT) && !issued_q && advance;
    rd_en    = (state_q != OUT) || advance;
    rd_addr  = (state_q == OUT) ? rd_cnt_q : in_index[DEPTH-1:1];
    // Write-after-read to the same address in the previous cycle is bypassed here.
    op_e     = fwd_q ? fwd_e_q : rd_e_q;
    op_o     = fwd_q ? fwd_o_q : rd_o_q;
    wr_e     = s1_first_q ? s1_din1_q : op_e + s1_din1_q;
    wr_o     = s1_first_q ? s1_din2_q : op_o + s1_din2_q;
    last_acc = xfer && (pair_cnt_q == '1) && (poly_cnt_q == 2'(K - 1));
    last_out = out_valid_q && out_ready && (out_index_q == {{AW{1'b1}}, 1'b0});
  end

  always_comb begin
    state_d     = state_q;
    pair_cnt_d  = pair_cnt_q;
    poly_cnt_d  = poly_cnt_q;
    s1_valid_d  = xfer;
    s1_first_d  = (poly_cnt_q == '0);
    s1_addr_d   = in_index[DEPTH-1:1];
    s1_din1_d   = $signed(acc_din_1);
    s1_din2_d   = $signed(acc_din_2);
    rd_cnt_d    = rd_cnt_q;
    issued_d    = issued_q;
    p1_valid_d  = p1_valid_q;
    p1_idx_d    = p1_idx_q;
    out_valid_d = out_valid_q;
    dout1_d     = dout1_q;
    dout2_d     = dout2_q;
    out_index_d = out_index_q;
    done_d      = 1'b0;

    if (xfer) begin
      pair_cnt_d = pair_cnt_q + 1'b1;
      if (pair_cnt_q == '1) begin
        poly_cnt_d = (poly_cnt_q == 2'(K - 1)) ? '0 : poly_cnt_q + 1'b1;
      end
    end

    if (advance) begin
      p1_valid_d  = issue;
      p1_idx_d    = rd_cnt_q;
      out_valid_d = p1_valid_q;
      if (p1_valid_q) begin
        dout1_d     = red_e;
        dout2_d     = red_o;
        out_index_d = {p1_idx_q, 1'b0};
      end
    end

    if (issue) begin
      rd_cnt_d = rd_cnt_q + 1'b1;
      issued_d = (rd_cnt_q == '1);
    end

    case (state_q)
      IDLE: if (set) state_d = ACC;
      ACC: begin
        if (last_acc) begin
          state_d  = OUT;
          rd_cnt_d = '0;
          issued_d = 1'b0;
        end
      end
      OUT: begin
        if (last_out) begin
          state_d = DONE;
          done_d  = 1'b1;
        end
      end
      DONE:    state_d = set ? ACC : IDLE;
      default: state_d = IDLE;
    endcase

    if (!set) begin
      state_d     = IDLE;
      s1_valid_d  = 1'b0;
      p1_valid_d  = 1'b0;
      out_valid_d = 1'b0;
      done_d      = 1'b0;
    end

    if (state_d != ACC) begin
      pair_cnt_d = '0;
      poly_cnt_d = '0;
    end
    in_ready_d = (state_d == ACC);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= IDLE;
      pair_cnt_q  <= '0;
      poly_cnt_q  <= '0;
      in_ready_q  <= 1'b0;
      s1_valid_q  <= 1'b0;
      s1_first_q  <= 1'b0;
      s1_addr_q   <= '0;
      s1_din1_q   <= '0;
      s1_din2_q   <= '0;
      rd_cnt_q    <= '0;
      issued_q    <= 1'b0;
      p1_valid_q  <= 1'b0;
      p1_idx_q    <= '0;
      out_valid_q <= 1'b0;
      dout1_q     <= '0;
      dout2_q     <= '0;
      out_index_q <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      pair_cnt_q  <= pair_cnt_d;
      poly_cnt_q  <= poly_cnt_d;
      in_ready_q  <= in_ready_d;
      s1_valid_q  <= s1_valid_d;
      s1_first_q  <= s1_first_d;
      s1_addr_q   <= s1_addr_d;
      s1_din1_q   <= s1_din1_d;
      s1_din2_q   <= s1_din2_d;
      rd_cnt_q    <= rd_cnt_d;
      issued_q    <= issued_d;
      p1_valid_q  <= p1_valid_d;
      p1_idx_q    <= p1_idx_d;
      out_valid_q <= out_valid_d;
      dout1_q     <= dout1_d;
      dout2_q     <= dout2_d;
      out_index_q <= out_index_d;
      done_q      <= done_d;
    end
  end

  // Storage banks: synchronous read, write one cycle after the read of the same transfer.
  always_ff @(posedge clk) begin
    if (s1_valid_q) begin
      mem_even[s1_addr_q] <= wr_e;
      mem_odd[s1_addr_q]  <= wr_o;
    end
    if (rd_en) begin
      rd_e_q  <= mem_even[rd_addr];
      rd_o_q  <= mem_odd[rd_addr];
      fwd_q   <= s1_valid_q && (s1_addr_q == rd_addr);
      fwd_e_q <= wr_e;
      fwd_o_q <= wr_o;
    end
  end

  assign in_ready   = in_ready_q;
  assign out_valid  = out_valid_q;
  assign acc_dout_1 = dout1_q;
  assign acc_dout_2 = dout2_q;
  assign out_index  = out_index_q;
  assign done       = done_q;

endmodule

// File: tb/tb_polyvec_acc.sv
// Scoreboard bench for polyvec_acc: a K=2 and a K=3 instance share the input bus,
// each enabled by its own set line; expected sums come from an integer model.
module tb_polyvec_acc;

  localparam int Q = 3329;

  logic        clk = 1'b0;
  logic        reset, set2, set3, in_valid, out_ready;
  logic [15:0] din1, din2;
  logic [7:0]  in_index;

  logic        rdy2, rdy3, ov2, ov3, done2, done3;
  logic [15:0] d1_2, d2_2, d1_3, d2_3;
  logic [7:0]  oi2, oi3;

  logic        in_ready, out_valid, done;
  logic [15:0] dout1, dout2;
  logic [7:0]  out_index;

  int sel = 2;
  int passed = 0;
  int total = 0;

  typedef struct {
    int idx;
    int d1;
    int d2;
  } exp_t;

  exp_t sb[$];
  int   model[256];

  always #5 clk = ~clk;

  polyvec_acc #(.DEPTH(8), .K(2), .KYBER_Q(Q)) dut2 (
    .clk(clk), .reset(reset), .set(set2), .in_valid(in_valid), .in_ready(rdy2),
    .acc_din_1(din1), .acc_din_2(din2), .in_index(in_index),
    .out_valid(ov2), .out_ready(out_ready), .acc_dout_1(d1_2), .acc_dout_2(d2_2),
    .out_index(oi2), .done(done2)
  );

  polyvec_acc #(.DEPTH(8), .K(3), .KYBER_Q(Q)) dut3 (
    .clk(clk), .reset(reset), .set(set3), .in_valid(in_valid), .in_ready(rdy3),
    .acc_din_1(din1), .acc_din_2(din2), .in_index(in_index),
    .out_valid(ov3), .out_ready(out_ready), .acc_dout_1(d1_3), .acc_dout_2(d2_3),
    .out_index(oi3), .done(done3)
  );

  always_comb begin
    if (sel == 3) begin
      in_ready = rdy3; out_valid = ov3; done = done3;
      dout1 = d1_3; dout2 = d2_3; out_index = oi3;
    end else begin
      in_ready = rdy2; out_valid = ov2; done = done2;
      dout1 = d1_2; dout2 = d2_2; out_index = oi2;
    end
  end

  function automatic int modq(input int x);
    int m = x % Q;
    if (m < 0) m += Q;
    return m;
  endfunction

  // stop_at < 0 sends every pair of every polynomial; otherwise stops after that many transfers.
  task automatic send_polys(input int kk, input int cval, input bit rnd, input bit gaps,
                            input int stop_at);
    int n = 0;
    exp_t e;
    for (int p = 0; p < kk; p++) begin
      for (int j = 0; j < 128; j++) begin
        int pr, v1, v2, w;
        if (n == stop_at) begin
          in_valid = 1'b0;
          return;
        end
        pr = (rnd && (p % 2 == 1)) ? 127 - j : j;
        if (rnd) begin
          v1 = int'($urandom_range(2 * Q - 2)) - (Q - 1);
          v2 = int'($urandom_range(2 * Q - 2)) - (Q - 1);
        end else begin
          v1 = cval;
          v2 = cval;
        end
        if (p == 0) begin
          model[2*pr] = v1; model[2*pr+1] = v2;
        end else begin
          model[2*pr] += v1; model[2*pr+1] += v2;
        end
        in_valid = 1'b1; din1 = 16'(v1); din2 = 16'(v2); in_index = 8'(2 * pr);
        w = 0;
        @(negedge clk);
        while (!in_ready && w < 20) begin
          @(negedge clk);
          w++;
        end
        if (!in_ready) begin
          total++;
          $display("FAIL send_handshake: in_ready=%0b required 1 within 20 cycles", in_ready);
          in_valid = 1'b0;
          return;
        end
        @(posedge clk); #1;
        n++;
        if (gaps && $urandom_range(3) == 0) begin
          in_valid = 1'b0;
          @(posedge clk); #1;
        end
      end
    end
    in_valid = 1'b0;
    for (int i = 0; i < 128; i++) begin
      e.idx = 2 * i; e.d1 = modq(model[2*i]); e.d2 = modq(model[2*i+1]);
      sb.push_back(e);
    end
  endtask

  task automatic collect(input int stall_at, input bit junk);
    int got = 0, post = 0, cyc = 0, dcnt = 0;
    bit stalled = 1'b0;
    exp_t e;
    logic [15:0] h1, h2;
    logic [7:0]  hi;
    out_ready = 1'b1;
    if (junk) begin
      in_valid = 1'b1; din1 = 16'd777; din2 = 16'd777; in_index = 8'd0;
    end
    while (post < 3 && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      if (got == 128) post++;
      if (done) begin
        dcnt++;
        in_valid = 1'b0;
      end
      if (post == 2) begin
        total++;
        if (in_ready !== 1'b1) $display("FAIL rearm_acc: in_ready=%0b required 1", in_ready);
        else passed++;
      end
      if (out_valid && got < 128) begin
        if (out_index == 8'(stall_at) && !stalled) begin
          stalled = 1'b1; out_ready = 1'b0;
          h1 = dout1; h2 = dout2; hi = out_index;
          repeat (3) begin
            @(negedge clk);
            cyc++;
            total++;
            if ({out_valid, out_index, dout1, dout2} !== {1'b1, hi, h1, h2})
              $display("FAIL stall_hold: v=%0b idx=%0d d1=%0d d2=%0d required v=1 idx=%0d d1=%0d d2=%0d",
                       out_valid, out_index, dout1, dout2, hi, h1, h2);
            else passed++;
          end
          out_ready = 1'b1;
        end
        total++;
        if (sb.size() == 0) begin
          $display("FAIL out_pair: idx=%0d with empty scoreboard, required no output", out_index);
        end else begin
          e = sb.pop_front();
          if ({out_index, dout1, dout2} !== {8'(e.idx), 16'(e.d1), 16'(e.d2)})
            $display("FAIL out_pair: idx=%0d d1=%0d d2=%0d required idx=%0d d1=%0d d2=%0d",
                     out_index, dout1, dout2, e.idx, e.d1, e.d2);
          else passed++;
        end
        got++;
      end
    end
    in_valid = 1'b0;
    total++;
    if (got !== 128) $display("FAIL out_count: got %0d pairs, required 128", got);
    else passed++;
    total++;
    if (dcnt !== 1) $display("FAIL done_pulse: %0d cycles high, required 1", dcnt);
    else passed++;
    if (sel == 3) set3 = 1'b0;
    else set2 = 1'b0;
    @(negedge clk);
    total++;
    if (in_ready !== 1'b0) $display("FAIL idle_after_clear: in_ready=%0b required 0", in_ready);
    else passed++;
  endtask

  task automatic test_reset;
    reset = 1'b0; set2 = 1'b0; set3 = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    din1 = '0; din2 = '0; in_index = '0; sel = 2;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    total++;
    if ({in_ready, out_valid, done} !== 3'b000)
      $display("FAIL reset_ctrl: ready/valid/done=%b required 000", {in_ready, out_valid, done});
    else passed++;
    total++;
    if ({out_index, dout1, dout2} !== 40'd0)
      $display("FAIL reset_data: idx=%0d d1=%0d d2=%0d required 0 0 0", out_index, dout1, dout2);
    else passed++;
  endtask

  task automatic test_ones_k2;
    sel = 2; set2 = 1'b1;
    send_polys(2, 1, 1'b0, 1'b0, -1);
    collect(-1, 1'b0);
  endtask

  task automatic test_neg_k2;
    sel = 2; set2 = 1'b1;
    send_polys(2, -1, 1'b0, 1'b0, -1);
    collect(-1, 1'b0);
  endtask

  task automatic test_k3;
    sel = 3; set3 = 1'b1;
    send_polys(3, 3000, 1'b0, 1'b0, -1);
    collect(-1, 1'b0);
    sel = 2;
  endtask

  task automatic test_stall;
    sel = 2; set2 = 1'b1;
    send_polys(2, 1, 1'b0, 1'b1, -1);
    collect(100, 1'b0);
  endtask

  task automatic test_ignore_in_out;
    sel = 2; set2 = 1'b1;
    send_polys(2, 1, 1'b0, 1'b0, -1);
    collect(-1, 1'b1);
  endtask

  task automatic test_reset_mid;
    sel = 2; set2 = 1'b1;
    send_polys(2, 1, 1'b0, 1'b0, 128 + 40);
    reset = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    total++;
    if ({in_ready, out_valid, done, out_index, dout1, dout2} !== 43'd0)
      $display("FAIL reset_mid: ready=%0b valid=%0b done=%0b idx=%0d d1=%0d d2=%0d required all 0",
               in_ready, out_valid, done, out_index, dout1, dout2);
    else passed++;
    sb.delete();
    send_polys(2, 5, 1'b0, 1'b0, -1);
    collect(-1, 1'b0);
  endtask

  task automatic test_back_to_back;
    sel = 2; set2 = 1'b1;
    send_polys(2, 0, 1'b1, 1'b0, -1);
    collect(-1, 1'b0);
    set2 = 1'b1;
    send_polys(2, 0, 1'b1, 1'b1, -1);
    collect(37, 1'b0);
  endtask

  task automatic test_abort;
    int w = 0;
    sel = 2; set2 = 1'b1;
    send_polys(2, 1, 1'b0, 1'b0, -1);
    out_ready = 1'b0;
    @(negedge clk);
    while (!out_valid && w < 20) begin
      @(negedge clk);
      w++;
    end
    total++;
    if (out_valid !== 1'b1) $display("FAIL abort_pre: out_valid=%0b required 1", out_valid);
    else passed++;
    set2 = 1'b0;
    @(negedge clk);
    total++;
    if ({out_valid, in_ready, done} !== 3'b000)
      $display("FAIL abort: valid/ready/done=%b required 000", {out_valid, in_ready, done});
    else passed++;
    sb.delete();
    out_ready = 1'b1;
  endtask

  initial begin
    test_reset();
    test_ones_k2();
    test_neg_k2();
    test_k3();
    test_stall();
    test_ignore_in_out();
    test_reset_mid();
    test_back_to_back();
    test_abort();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
